// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite master: FSM state encoding,
// response codes and default bus widths.
package axi_lite_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-lite master. Accepts one local command at a time,
// runs it on the AXI-lite channels and reports completion with a one-cycle
// rsp_valid pulse carrying read data (0 for writes) and the slave response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb   local command request
//   rsp_valid/rdata/resp          completion pulse and result
//   aw*/w*/b*                     AXI-lite write address, data, response
//   ar*/r*                        AXI-lite read address, data
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic                      awvalid,
    input  logic                      awready,

    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,

    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,

    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      arvalid,
    input  logic                      arready,

    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    write_q, write_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic                    aw_hs_c, w_hs_c, done_c;

    // Handshakes are qualified by our own registered valid/ready.
    assign aw_hs_c = (state_q == ST_WR) && awvalid_q && awready;
    assign w_hs_c  = (state_q == ST_WR) && wvalid_q && wready;
    assign done_c  = (bvalid && bready_q) || (rvalid && rready_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            ST_WR: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Leave once both channels have finished, counting this cycle's handshakes.
                if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end

            ST_RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            ST_WR_RESP, ST_RD_DATA: begin
                // Completion handled below; both share the capture path.
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only one of bready/rready is ever high, so done_c identifies a single completion.
        if (done_c) begin
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = write_q ? bresp : rresp;
            rsp_rdata_d = write_q ? '0 : rdata;
            state_d     = ST_RESP;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Command acceptance is gated by rst so nothing is taken while in reset.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // Address and data come straight from the command registers, so they
    // stay stable for the whole life of their valid.
    assign awaddr  = addr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign araddr  = addr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: zero-wait write, split aw/w write,
// slow read with error response, held cmd_valid, and mid-write reset.
module tb_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    axi_lite_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_awvalid",   64'(awvalid),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Zero-wait write: addr 3, DEADBEEF, strb F
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        tick();                                          // cycle 1
        cmd_valid = 1'b0;
        check("w0_c1_awvalid", 64'(awvalid), 64'd1);
        check("w0_c1_wvalid",  64'(wvalid),  64'd1);
        check("w0_c1_awaddr",  64'(awaddr),  64'h3);
        check("w0_c1_wdata",   64'(wdata),   64'hDEADBEEF);
        check("w0_c1_wstrb",   64'(wstrb),   64'hF);
        check("w0_c1_bready",  64'(bready),  64'd0);
        check("w0_c1_cmd_rdy", 64'(cmd_ready), 64'd0);
        tick();                                          // cycle 2
        check("w0_c2_awvalid", 64'(awvalid), 64'd0);
        check("w0_c2_wvalid",  64'(wvalid),  64'd0);
        check("w0_c2_bready",  64'(bready),  64'd1);
        check("w0_c2_rsp_vld", 64'(rsp_valid), 64'd0);
        tick();                                          // cycle 3
        bvalid = 1'b0;
        check("w0_c3_rsp_vld", 64'(rsp_valid), 64'd1);
        check("w0_c3_rsp_resp",64'(rsp_resp),  64'd0);
        check("w0_c3_rsp_data",64'(rsp_rdata), 64'd0);
        check("w0_c3_bready",  64'(bready),    64'd0);
        tick();                                          // cycle 4
        check("w0_c4_rsp_vld", 64'(rsp_valid), 64'd0);
        check("w0_c4_cmd_rdy", 64'(cmd_ready), 64'd1);

        // Write with awready three cycles ahead of wready, DECERR response
        awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA;
        cmd_wdata = 32'h0000_00FF; cmd_wstrb = 4'h1;
        tick();                                          // cycle 1: aw handshake
        cmd_valid = 1'b0;
        check("w1_c1_awvalid", 64'(awvalid), 64'd1);
        check("w1_c1_wvalid",  64'(wvalid),  64'd1);
        tick();                                          // cycle 2
        awready = 1'b0;
        check("w1_c2_awvalid", 64'(awvalid), 64'd0);
        check("w1_c2_wvalid",  64'(wvalid),  64'd1);
        check("w1_c2_bready",  64'(bready),  64'd0);
        tick();                                          // cycle 3
        check("w1_c3_wvalid",  64'(wvalid),  64'd1);
        check("w1_c3_wdata",   64'(wdata),   64'hFF);
        tick();                                          // cycle 4: w handshake
        wready = 1'b1;
        check("w1_c4_wvalid",  64'(wvalid),  64'd1);
        check("w1_c4_bready",  64'(bready),  64'd0);
        tick();                                          // cycle 5
        wready = 1'b0;
        check("w1_c5_wvalid",  64'(wvalid),  64'd0);
        check("w1_c5_bready",  64'(bready),  64'd1);
        tick();                                          // cycle 6: b handshake
        bvalid = 1'b1; bresp = 2'b11;
        check("w1_c6_bready",  64'(bready),  64'd1);
        check("w1_c6_rsp_vld", 64'(rsp_valid), 64'd0);
        tick();                                          // cycle 7
        bvalid = 1'b0; bresp = 2'b00;
        check("w1_c7_rsp_vld", 64'(rsp_valid), 64'd1);
        check("w1_c7_rsp_resp",64'(rsp_resp),  64'h3);
        check("w1_c7_bready",  64'(bready),    64'd0);
        tick();                                          // cycle 8
        check("w1_c8_bready",  64'(bready),    64'd0);
        check("w1_c8_rsp_vld", 64'(rsp_valid), 64'd0);
        check("w1_c8_rsp_resp",64'(rsp_resp),  64'h3);

        // Read addr 5, data after 4 wait cycles with SLVERR, cmd_valid held
        arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h5;
        tick();                                          // cycle 1
        check("r0_c1_arvalid", 64'(arvalid), 64'd1);
        check("r0_c1_araddr",  64'(araddr),  64'h5);
        check("r0_c1_cmd_rdy", 64'(cmd_ready), 64'd0);
        tick();                                          // cycle 2
        check("r0_c2_arvalid", 64'(arvalid), 64'd0);
        check("r0_c2_rready",  64'(rready),  64'd1);
        check("r0_c2_cmd_rdy", 64'(cmd_ready), 64'd0);
        tick();                                          // cycle 3
        check("r0_c3_cmd_rdy", 64'(cmd_ready), 64'd0);
        tick();                                          // cycle 4
        check("r0_c4_rready",  64'(rready),  64'd1);
        tick();                                          // cycle 5
        check("r0_c5_cmd_rdy", 64'(cmd_ready), 64'd0);
        tick();                                          // cycle 6: r handshake
        rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b10;
        check("r0_c6_rsp_vld", 64'(rsp_valid), 64'd0);
        tick();                                          // cycle 7
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        cmd_addr = 4'h9;
        check("r0_c7_rsp_vld", 64'(rsp_valid), 64'd1);
        check("r0_c7_rsp_data",64'(rsp_rdata), 64'h12345678);
        check("r0_c7_rsp_resp",64'(rsp_resp),  64'h2);
        check("r0_c7_cmd_rdy", 64'(cmd_ready), 64'd0);
        check("r0_c7_rready",  64'(rready),    64'd0);
        tick();                                          // cycle 8: second cmd taken
        check("r1_c8_cmd_rdy", 64'(cmd_ready), 64'd1);
        check("r1_c8_rsp_vld", 64'(rsp_valid), 64'd0);
        tick();                                          // cycle 9
        cmd_valid = 1'b0;
        check("r1_c9_arvalid", 64'(arvalid), 64'd1);
        check("r1_c9_araddr",  64'(araddr),  64'h9);
        check("r1_c9_hold",    64'(rsp_rdata), 64'h12345678);
        tick();                                          // cycle 10
        rvalid = 1'b1; rdata = 32'hA5A50F0F; rresp = 2'b00;
        check("r1_c10_rready", 64'(rready), 64'd1);
        tick();                                          // cycle 11
        rvalid = 1'b0; rdata = 32'h0;
        arready = 1'b0;
        check("r1_c11_rsp_vld",64'(rsp_valid), 64'd1);
        check("r1_c11_rsp_dat",64'(rsp_rdata), 64'hA5A50F0F);
        check("r1_c11_rsp_rsp",64'(rsp_resp),  64'h0);
        tick();                                          // cycle 12
        check("r1_c12_cmd_rdy",64'(cmd_ready), 64'd1);

        // Reset while the write waits on wready
        awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC;
        cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h3;
        tick();                                          // cycle 1
        cmd_valid = 1'b0;
        tick();                                          // cycle 2
        awready = 1'b0;
        check("x_c2_wvalid",   64'(wvalid),  64'd1);
        check("x_c2_awvalid",  64'(awvalid), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("x_rst_wvalid",  64'(wvalid),    64'd0);
        check("x_rst_awvalid", 64'(awvalid),   64'd0);
        check("x_rst_bready",  64'(bready),    64'd0);
        check("x_rst_rsp_dat", 64'(rsp_rdata), 64'd0);
        check("x_rst_cmd_rdy", 64'(cmd_ready), 64'd0);
        wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("x_post_cmd_rdy",64'(cmd_ready), 64'd1);
        tick();
        check("x_post_rsp_vld",64'(rsp_valid), 64'd0);
        check("x_post_bready", 64'(bready),    64'd0);
        check("x_post_wvalid", 64'(wvalid),    64'd0);
        tick();
        check("x_post2_rsp_vld",64'(rsp_valid), 64'd0);
        check("x_post2_rsp_rsp",64'(rsp_resp),  64'd0);
        check("x_post2_cmd_rdy",64'(cmd_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 ADDR_WIDTH, default 4, AXI-lite address width.
REQ-002 DATA_WIDTH, default 32, AXI-lite data width; wstrb width is DATA_WIDTH/8.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  local command request.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_WIDTH  target address.
REQ-009 cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-013 rsp_resp  out  2  bresp or rresp of the completed transaction.
REQ-014 awaddr / awvalid  out  ADDR_WIDTH / 1  write address channel; awready in 1.
REQ-015 wdata / wstrb / wvalid  out  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel; wready in 1.
REQ-016 bresp in 2, bvalid in 1, bready out 1  write response channel.
REQ-017 araddr / arvalid  out  ADDR_WIDTH / 1  read address channel; arready in 1.
REQ-018 rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1  read data channel.

Function
REQ-019 The FSM SHALL have states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP, with at most one transaction outstanding.
REQ-020 cmd_ready SHALL be high only in IDLE with rst low; on cmd_valid&&cmd_ready, cmd_addr/wdata/wstrb/write SHALL be registered, and the FSM SHALL go to WR or RD_ADDR.
REQ-021 In WR, awvalid and wvalid SHALL both assert on the first cycle, and each SHALL deassert independently on the cycle after its own ready is sampled high.
REQ-022 WR SHALL exit to WR_RESP on the cycle after both handshakes have completed; simultaneous awready and wready SHALL complete both in that same cycle.
REQ-023 bready SHALL be high only in WR_RESP; a bvalid arriving earlier SHALL be left waiting.
REQ-024 On bvalid&&bready, bresp SHALL be captured into rsp_resp and rsp_rdata cleared, then RESP.
REQ-025 In RD_ADDR, arvalid SHALL be high; on arready the FSM SHALL go to RD_DATA, where rready SHALL be high.
REQ-026 On rvalid&&rready, rdata/rresp SHALL be captured, then RESP.
REQ-027 RESP SHALL last exactly one cycle with rsp_valid=1, then IDLE; rsp_rdata/rsp_resp SHALL hold until the next completion.
REQ-028 All AXI valid outputs SHALL be registered, never combinationally dependent on any ready, and SHALL never drop before their handshake.
REQ-029 awaddr, wdata, wstrb and araddr SHALL be stable while their valid is high.
REQ-030 With zero-wait slaves, latency from cmd handshake (cycle 0) to rsp_valid SHALL be 3 cycles for writes and 3 cycles for reads; next cmd_ready SHALL assert at cycle 4.
REQ-031 cmd_valid outside IDLE SHALL be ignored without side effects.
REQ-032 Non-OKAY responses (2'b10, 2'b11) SHALL be passed through unchanged on rsp_resp, with no retry.

Reset
REQ-033 Asserting rst SHALL, at any time including mid-transaction, force IDLE and clear awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_rdata and rsp_resp to 0, with no response generated for the aborted command.

Structure
REQ-034 Package axi_lite_pkg SHALL hold the state enum, the response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10 and DECERR=2'b11, and the default width constants.
REQ-035 No sub-module is required; the design is a single FSM with aw_done/w_done flags.

Verification
REQ-036 Write addr 4'h3, data 32'hDEADBEEF, wstrb 4'hF, zero-wait slave -> aw/w handshake at cycle 1, bready at cycle 2, rsp_valid at cycle 3 with rsp_resp=00.
REQ-037 Write with awready 3 cycles before wready -> awvalid drops after its handshake, wvalid holds until wready, and exactly one bready window follows.
REQ-038 Read addr 4'h5, slave returns 32'h12345678 after 4 wait cycles with rresp=10 -> rsp_valid pulse with rsp_rdata=32'h12345678 and rsp_resp=10.
REQ-039 cmd_valid held high during an active read -> cmd_ready stays 0 and the second command is accepted only at the IDLE cycle after rsp_valid.
REQ-040 rst asserted while WR is waiting on wready -> all valids go 0 asynchronously, no rsp_valid, and cmd_ready=1 on the first cycle after rst deasserts.
